rom_mapper_detect: RTL and testbench



---
 rtl/mapper_pkg.sv | 19 +
 rtl/mapper_sig_match.sv | 62 ++++++
 rtl/rom_mapper_detect.sv | 106 ++++++++++
 tb/tb_rom_mapper_detect.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mapper_pkg.sv
// mapper_pkg: mapper codes, FSM/matcher states, bank-switch trigger addresses and the GM2 title string.
// Shared by rom_mapper_detect and mapper_sig_match; GM2 search is built only with MAPPER_DETECT_GM2_EN.
package mapper_pkg;
  typedef enum logic [2:0] {
    MAP_UNKNOWN, MAP_NONE, MAP_GM2, MAP_KONAMI, MAP_SCC, MAP_ASCII8, MAP_ASCII16
  } mapper_t;
  typedef enum logic [1:0] {M0, M1, M2} match_t;
  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} fsm_t;
  localparam logic [7:0] OP_LD = 8'h32;
  localparam logic [15:0] KON_0 = 16'h4000, KON_1 = 16'h8000, KON_2 = 16'hA000;
  localparam logic [15:0] SCC_0 = 16'h5000, SCC_1 = 16'h9000, SCC_2 = 16'hB000;
  localparam logic [15:0] A8_0 = 16'h6800, A8_1 = 16'h7800, A16_0 = 16'h77FF;
  localparam logic [15:0] BOTH_0 = 16'h6000, BOTH_1 = 16'h7000;
  localparam int GM2_LEN = 13;
  localparam logic [8*GM2_LEN-1:0] GM2_STR = "GAME MASTER 2";
  function automatic logic [7:0] gm2_char(input logic [3:0] i);
    return GM2_STR[8*(GM2_LEN-1-int'(i)) +: 8];
  endfunction
endpackage

// File: rtl/mapper_sig_match.sv
// mapper_sig_match: LD (nn),A matcher and trigger-address classifier, one-cycle hit pulses
// (konami, scc, ascii8, ascii16). MAPPER_DETECT_GM2_EN adds the "GAME MASTER 2" string search.
module mapper_sig_match
  import mapper_pkg::*;
(
  input  logic        clk21m,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        wr,
  input  logic [26:0] addr,
  input  logic [7:0]  dout,
  output logic [3:0]  hit,
  output logic        gm2_hit
);
  match_t m_q, m_d, ms;
  logic [7:0] lo_q, lo_d;
  logic [26:0] last_q, last_d;
  logic [15:0] a;
  logic seq, strobe, score;
  always_comb begin
    strobe = en & wr;
    seq = addr == last_q + 27'd1;
    ms = seq ? m_q : M0;
    a = {dout, lo_q};
    score = strobe & (ms == M2);
    m_d = clr ? M0 : !strobe ? m_q : ms == M0 ? (dout == OP_LD ? M1 : M0) : ms == M1 ? M2 : M0;
    lo_d = clr ? 8'd0 : (strobe & (ms == M1)) ? dout : lo_q;
    last_d = clr ? 27'd0 : strobe ? addr : last_q;
    hit[0] = score & (a == KON_0 | a == KON_1 | a == KON_2);
    hit[1] = score & (a == SCC_0 | a == SCC_1 | a == SCC_2);
    hit[2] = score & (a == A8_0 | a == A8_1 | a == BOTH_0 | a == BOTH_1);
    hit[3] = score & (a == A16_0 | a == BOTH_0 | a == BOTH_1);
  end
  always_ff @(posedge clk21m or posedge reset)
    if (reset) begin
      m_q <= M0;
      lo_q <= 8'd0;
      last_q <= 27'd0;
    end else begin
      m_q <= m_d;
      lo_q <= lo_d;
      last_q <= last_d;
    end
`ifdef MAPPER_DETECT_GM2_EN
  logic [3:0] gidx_q, gidx_d, gi;
  logic gmatch;
  // a mismatching 'G' may itself start a new title match
  always_comb begin
    gi = seq ? gidx_q : 4'd0;
    gmatch = dout == gm2_char(gi);
    gidx_d = clr ? 4'd0 : !strobe ? gidx_q :
             gmatch ? (gi == 4'(GM2_LEN-1) ? 4'd0 : gi + 4'd1) : {3'd0, dout == "G"};
    gm2_hit = strobe & gmatch & (gi == 4'(GM2_LEN-1));
  end
  always_ff @(posedge clk21m or posedge reset)
    if (reset) gidx_q <= 4'd0;
    else gidx_q <= gidx_d;
`else
  assign gm2_hit = 1'b0;
`endif
endmodule

// File: rtl/rom_mapper_detect.sv
// rom_mapper_detect: passive slot-A ROM download snooper classifying the cartridge mapper.
// Define MAPPER_DETECT_GM2_EN to enable the GAME MASTER 2 title override.
module rom_mapper_detect
  import mapper_pkg::*;
#(
  parameter int          CNT_W       = 8,
  parameter logic [26:0] NOMAP_LIMIT = 27'h10000,
  parameter int          MIN_HITS    = 2
) (
  input  logic        clk21m,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        scan_en,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [2:0]  mapper_info,
  output logic        detect_valid,
  output logic        busy
);
  fsm_t state_q, state_d;
  mapper_t map_q, map_d, best_code;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] best_cnt;
  logic [26:0] max_q, max_d;
  logic [3:0] hit;
  logic [1:0] bi;
  logic valid_q, valid_d, busy_q, busy_d, gm2_q, gm2_d, gm2_hit, clr, en;
  mapper_sig_match u_match (
    .clk21m (clk21m),
    .reset  (reset),
    .clr    (clr),
    .en     (en),
    .wr     (ioctl_wr),
    .addr   (ioctl_addr),
    .dout   (ioctl_dout),
    .hit    (hit),
    .gm2_hit(gm2_hit)
  );
  always_comb begin
    state_d = state_q;
    map_d = map_q;
    valid_d = valid_q;
    busy_d = busy_q;
    clr = 1'b0;
    en = state_q == SCAN;
    // strict '>' keeps the earlier counter on ties: Konami, SCC, ASCII8, ASCII16
    best_cnt = cnt_q[0];
    bi = 2'd0;
    for (int i = 1; i < 4; i++)
      if (cnt_q[i] > best_cnt) begin
        best_cnt = cnt_q[i];
        bi = 2'(i);
      end
    best_code = mapper_t'(3'(MAP_KONAMI) + {1'b0, bi});
    case (state_q)
      IDLE:
        if (ioctl_download & scan_en) begin
          state_d = SCAN;
          clr = 1'b1;
          busy_d = 1'b1;
          valid_d = 1'b0;
        end
      SCAN:
        if (!ioctl_download) state_d = DECIDE;
        else if (!scan_en) begin
          state_d = IDLE;
          busy_d = 1'b0;
          valid_d = 1'b0;
        end
      DECIDE: begin
        state_d = IDLE;
        busy_d = 1'b0;
        valid_d = 1'b1;
        map_d = gm2_q ? MAP_GM2 : max_q < NOMAP_LIMIT ? MAP_NONE :
                best_cnt >= CNT_W'(MIN_HITS) ? best_code : MAP_UNKNOWN;
      end
      default: state_d = IDLE;
    endcase
    for (int i = 0; i < 4; i++)
      cnt_d[i] = clr ? '0 : (hit[i] & ~&cnt_q[i]) ? cnt_q[i] + 1'b1 : cnt_q[i];
    max_d = clr ? 27'd0 : (en & ioctl_wr & (ioctl_addr > max_q)) ? ioctl_addr : max_q;
    gm2_d = clr ? 1'b0 : gm2_q | gm2_hit;
  end
  always_ff @(posedge clk21m or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      map_q <= MAP_UNKNOWN;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      cnt_q <= '0;
      max_q <= 27'd0;
      gm2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      map_q <= map_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      max_q <= max_d;
      gm2_q <= gm2_d;
    end
  assign mapper_info = map_q;
  assign detect_valid = valid_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_rom_mapper_detect.sv
// tb_rom_mapper_detect: scoreboard bench for rom_mapper_detect; expected codes are queued when a
// download ends and compared when detect_valid rises. GM2 expectations follow MAPPER_DETECT_GM2_EN.
module tb_rom_mapper_detect;
  logic clk21m = 1'b0, reset = 1'b1, ioctl_download = 1'b0, scan_en = 1'b0, ioctl_wr = 1'b0;
  logic [26:0] ioctl_addr = 27'd0;
  logic [7:0] ioctl_dout = 8'd0;
  logic [2:0] mapper_info;
  logic detect_valid, busy, valid_prev = 1'b0;
  int n_chk = 0, n_pass = 0;
  logic [2:0] exp_code_q[$];
  string exp_tag_q[$];
`ifdef MAPPER_DETECT_GM2_EN
  localparam logic [2:0] EXP_GM2 = 3'd2;
`else
  localparam logic [2:0] EXP_GM2 = 3'd3;
`endif
  always #5 clk21m = ~clk21m;
  rom_mapper_detect dut (
    .clk21m        (clk21m),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .scan_en       (scan_en),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .mapper_info   (mapper_info),
    .detect_valid  (detect_valid),
    .busy          (busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  always @(negedge clk21m) begin
    if (detect_valid && !valid_prev) begin
      if (exp_code_q.size() == 0) check("unexpected_result", exp_code_q.size(), 1);
      else check(exp_tag_q.pop_front(), mapper_info, exp_code_q.pop_front());
    end
    valid_prev <= detect_valid;
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk21m);
    #1;
  endtask
  task automatic wr(input logic [26:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask
  task automatic ld(input logic [26:0] a, input logic [15:0] t);
    wr(a, 8'h32);
    wr(a + 27'd1, t[7:0]);
    wr(a + 27'd2, t[15:8]);
  endtask
  task automatic begin_dl(input logic se);
    ioctl_download = 1'b1;
    scan_en = se;
    tick();
  endtask
  task automatic end_dl(input string tag, input logic [2:0] code);
    exp_tag_q.push_back(tag);
    exp_code_q.push_back(code);
    ioctl_download = 1'b0;
    tick();
    ioctl_wr = 1'b0;
    check({tag, "_valid_early"}, detect_valid, 0);
    tick();
    check({tag, "_valid"}, detect_valid, 1);
    check({tag, "_busy_clr"}, busy, 0);
    scan_en = 1'b0;
    tick();
  endtask
  task automatic gm2_image();
    string s = "GAGAME MASTER 2";
    for (int i = 0; i < s.len(); i++) wr(27'h8000 + 27'(i), s[i]);
    ld(27'h9000, 16'h4000);
    ld(27'h9003, 16'h8000);
    wr(27'h3FFFF, 8'h00);
  endtask
  initial begin
    tick(2);
    check("rst_info", mapper_info, 0);
    check("rst_valid", detect_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    begin_dl(1'b1);
    check("scan_busy", busy, 1);
    for (int i = 0; i < 256; i++) wr(27'(i), 8'h00);
    wr(27'h7FFF, 8'h00);
    end_dl("nomap", 3'd1);
    begin_dl(1'b1);
    check("entry_valid_clr", detect_valid, 0);
    check("entry_info_hold", mapper_info, 1);
    ld(27'h100, 16'h6000);
    ld(27'h103, 16'h7000);
    ld(27'h106, 16'h6800);
    wr(27'h1FFFF, 8'h00);
    end_dl("ascii8", 3'd5);
    begin_dl(1'b1);
    ld(27'h200, 16'h5000);
    ld(27'h300, 16'h9000);
    ld(27'h400, 16'h8000);
    wr(27'h1FFFF, 8'h00);
    end_dl("scc", 3'd4);
    begin_dl(1'b1);
    ld(27'h200, 16'h5000);
    ld(27'h300, 16'h9000);
    ld(27'h400, 16'h8000);
    ld(27'h500, 16'h4000);
    wr(27'h1FFFF, 8'h00);
    end_dl("tie_konami", 3'd3);
    begin_dl(1'b1);
    wr(27'h1FFFE, 8'h32);
    wr(27'h1FFFF, 8'h00);
    wr(27'h20005, 8'h77);
    end_dl("gap_unknown", 3'd0);
    begin_dl(1'b1);
    ld(27'h1FFF0, 16'h77FF);
    wr(27'h1FFF3, 8'h32);
    wr(27'h1FFF4, 8'hFF);
    ioctl_wr = 1'b1;
    ioctl_addr = 27'h1FFF5;
    ioctl_dout = 8'h77;
    end_dl("ascii16_fall_byte", 3'd6);
    begin_dl(1'b1);
    for (int i = 0; i < 257; i++) ld(27'h1000 + 27'(3 * i), 16'h4000);
    ld(27'h2000, 16'h5000);
    ld(27'h2003, 16'h9000);
    wr(27'h1FFFF, 8'h00);
    end_dl("saturate", 3'd3);
    begin_dl(1'b1);
    ld(27'h10, 16'h5000);
    scan_en = 1'b0;
    tick();
    check("abandon_busy", busy, 0);
    check("abandon_valid", detect_valid, 0);
    ioctl_download = 1'b0;
    tick(3);
    check("abandon_info_hold", mapper_info, 3);
    check("abandon_no_result", detect_valid, 0);
    begin_dl(1'b1);
    ld(27'h20, 16'h4000);
    #2 reset = 1'b1;
    @(negedge clk21m);
    check("midrst_info", mapper_info, 0);
    check("midrst_valid", detect_valid, 0);
    check("midrst_busy", busy, 0);
    reset = 1'b0;
    ioctl_download = 1'b0;
    scan_en = 1'b0;
    tick(2);
    begin_dl(1'b1);
    for (int i = 0; i < 64; i++) wr(27'(i), 8'h00);
    wr(27'h7FFF, 8'h00);
    end_dl("post_rst_nomap", 3'd1);
    begin_dl(1'b1);
    gm2_image();
    end_dl("gm2", EXP_GM2);
    begin_dl(1'b0);
    check("slotb_busy", busy, 0);
    gm2_image();
    ioctl_download = 1'b0;
    tick(3);
    check("slotb_info", mapper_info, EXP_GM2);
    check("slotb_valid", detect_valid, 1);
    check("slotb_busy_end", busy, 0);
    tick(2);
    check("sb_empty", exp_code_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
